// File: rtl/booth_mul_seq_if.sv
// booth_mul_seq_if: handshake and operand/result bundle for the sequential Booth multiplier.
//   master: drives start, is_signed, multiplicand, multiplier; observes ready/busy/done and the product.
//   slave : the multiplier side of the same signals.
interface booth_mul_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] multiplicand;
    logic [WIDTH-1:0] multiplier;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] product_hi;
    logic [WIDTH-1:0] product_lo;
    modport master (
        output start, is_signed, multiplicand, multiplier,
        input  ready, busy, done, product_hi, product_lo
    );
    modport slave (
        input  start, is_signed, multiplicand, multiplier,
        output ready, busy, done, product_hi, product_lo
    );
endinterface

// File: rtl/booth_mul_seq.sv
// booth_mul_seq: multi-cycle radix-4 Booth multiplier, one recoded digit per clock.
//   clk   : rising-edge clock
//   clr_n : asynchronous active-low reset
//   bus   : slave side of booth_mul_seq_if (start/is_signed/operands in; ready/busy/done/product out)
module booth_mul_seq #(
    parameter int WIDTH = 32
) (
    input logic            clk,
    input logic            clr_n,
    booth_mul_seq_if.slave bus
);
    localparam int EW = WIDTH + 2;
    localparam int AW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH / 2 + 2);
    localparam logic [CW-1:0] N_S = CW'(WIDTH / 2);
    localparam logic [CW-1:0] N_U = CW'(WIDTH / 2 + 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t          r_state, w_next;
    // Only the low 2*WIDTH product bits are kept; modular arithmetic keeps them exact.
    logic [AW-1:0]   r_mc, r_acc, w_mag, w_pp;
    // Extended multiplier with the implicit b[-1] appended as bit 0.
    logic [EW:0]     r_mq;
    logic [CW-1:0]   r_cnt, r_last;
    logic [WIDTH-1:0] r_hi, r_lo;
    logic [2:0]      w_dig;
    logic            w_sa, w_sb;
    assign w_sa  = bus.is_signed & bus.multiplicand[WIDTH-1];
    assign w_sb  = bus.is_signed & bus.multiplier[WIDTH-1];
    assign w_dig = r_mq[2:0];
    always_comb begin
        w_mag = (w_dig == 3'b011 || w_dig == 3'b100) ? r_mc << 1 :
                (w_dig == 3'b000 || w_dig == 3'b111) ? '0 : r_mc;
        w_pp  = w_dig[2] ? -w_mag : w_mag;
    end
    always_comb begin
        w_next = r_state;
        w_next = (r_state == IDLE) ? (bus.start ? RUN : IDLE) :
                 (r_state == RUN)  ? ((r_cnt == r_last) ? DONE : RUN) : IDLE;
    end
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) r_state <= IDLE;
        else        r_state <= w_next;
    end
    // r_mc moves left two bits per digit so each partial product lands at weight 4^k;
    // the multiplier shifts right arithmetically so the next digit is always bits [2:0].
    // The extra RUN cycle with r_cnt == r_last transfers the finished sum to the outputs.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_mc   <= '0;
            r_mq   <= '0;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_last <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
        end else if (r_state == IDLE && bus.start) begin
            r_mc   <= {{(AW-WIDTH){w_sa}}, bus.multiplicand};
            r_mq   <= {{2{w_sb}}, bus.multiplier, 1'b0};
            r_acc  <= '0;
            r_cnt  <= '0;
            r_last <= bus.is_signed ? N_S : N_U;
        end else if (r_state == RUN) begin
            if (r_cnt == r_last) begin
                {r_hi, r_lo} <= r_acc;
            end else begin
                r_acc <= r_acc + w_pp;
                r_mc  <= r_mc << 2;
                r_mq  <= {{2{r_mq[EW]}}, r_mq[EW:2]};
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end
    assign bus.ready      = (r_state == IDLE);
    assign bus.busy       = (r_state != IDLE);
    assign bus.done       = (r_state == DONE);
    assign bus.product_hi = r_hi;
    assign bus.product_lo = r_lo;
endmodule

// File: tb/tb_booth_mul_seq.sv
// tb_booth_mul_seq: directed-vector and handshake/reset checks for booth_mul_seq at WIDTH=32.
module tb_booth_mul_seq;
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [63:0] p;
    } vec_t;
    logic clk = 1'b0;
    logic clr_n = 1'b0;
    int   n_pass = 0;
    int   n_tot = 0;
    vec_t tbl[14];
    booth_mul_seq_if #(.WIDTH(32)) bus();
    booth_mul_seq #(.WIDTH(32)) dut (.clk(clk), .clr_n(clr_n), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [63:0] exp, input string nm);
        int k = 0;
        bus.multiplicand = a;
        bus.multiplier   = b;
        bus.is_signed    = s;
        bus.start        = 1'b1;
        @(posedge clk); #1;
        bus.start        = 1'b0;
        bus.multiplicand = ~a;
        bus.multiplier   = ~b;
        bus.is_signed    = ~s;
        do begin
            @(posedge clk); #1;
            k++;
        end while (!bus.done && k < 40);
        chk({nm, " latency"}, 64'(k), s ? 64'd17 : 64'd18);
        chk({nm, " product"}, {bus.product_hi, bus.product_lo}, exp);
        @(posedge clk); #1;
        chk({nm, " done pulse"}, {63'd0, bus.done}, 64'd0);
        chk({nm, " ready after"}, {63'd0, bus.ready}, 64'd1);
    endtask
    initial begin
        logic [63:0] prev, ea, eb;
        logic [31:0] ra, rb;
        logic        rs;
        tbl[0]  = '{32'd7,        32'hFFFFFFFD, 1'b1, 64'hFFFFFFFF_FFFFFFEB};
        tbl[1]  = '{32'h80000000, 32'h80000000, 1'b1, 64'h40000000_00000000};
        tbl[2]  = '{32'h80000000, 32'h7FFFFFFF, 1'b1, 64'hC0000000_80000000};
        tbl[3]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE_00000001};
        tbl[4]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h00000000_00000001};
        tbl[5]  = '{32'd0,        32'h12345678, 1'b0, 64'd0};
        tbl[6]  = '{32'hDEADBEEF, 32'd1,        1'b0, 64'h00000000_DEADBEEF};
        tbl[7]  = '{32'hDEADBEEF, 32'd1,        1'b1, 64'hFFFFFFFF_DEADBEEF};
        tbl[8]  = '{32'd5,        32'd6,        1'b1, 64'd30};
        tbl[9]  = '{32'h00010000, 32'h00010000, 1'b0, 64'h00000001_00000000};
        tbl[10] = '{32'h80000000, 32'd2,        1'b0, 64'h00000001_00000000};
        tbl[11] = '{32'h80000000, 32'd2,        1'b1, 64'hFFFFFFFF_00000000};
        tbl[12] = '{32'hFFFFFFFF, 32'd2,        1'b1, 64'hFFFFFFFF_FFFFFFFE};
        tbl[13] = '{32'd2,        32'h80000000, 1'b0, 64'h00000001_00000000};
        bus.start = 1'b0;
        bus.is_signed = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset ready", {63'd0, bus.ready}, 64'd1);
        chk("reset busy", {63'd0, bus.busy}, 64'd0);
        chk("reset done", {63'd0, bus.done}, 64'd0);
        chk("reset product", {bus.product_hi, bus.product_lo}, 64'd0);
        clr_n = 1'b1;
        for (int i = 0; i < 14; i++) run_op(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].p, $sformatf("vec%0d", i));
        for (int i = 0; i < 60; i++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'(i & 1);
            ea = rs ? {{32{ra[31]}}, ra} : {32'd0, ra};
            eb = rs ? {{32{rb[31]}}, rb} : {32'd0, rb};
            run_op(ra, rb, rs, ea * eb, $sformatf("rand%0d", i));
        end
        prev = {bus.product_hi, bus.product_lo};
        bus.multiplicand = 32'd3;
        bus.multiplier   = 32'd4;
        bus.is_signed    = 1'b1;
        bus.start        = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            @(posedge clk); #1;
            if (k <= 16) begin
                chk($sformatf("hs ready c%0d", k), {63'd0, bus.ready}, 64'd0);
                chk($sformatf("hs hold c%0d", k), {bus.product_hi, bus.product_lo}, prev);
                chk($sformatf("hs done c%0d", k), {63'd0, bus.done}, 64'd0);
            end
            if (k == 17) begin
                chk("hs done c17", {63'd0, bus.done}, 64'd1);
                chk("hs busy c17", {63'd0, bus.busy}, 64'd1);
                chk("hs product", {bus.product_hi, bus.product_lo}, 64'd12);
            end
            if (k == 18) begin
                chk("hs ready c18", {63'd0, bus.ready}, 64'd1);
                chk("hs product c18", {bus.product_hi, bus.product_lo}, 64'd12);
            end
            bus.start = (k == 3 || k == 17);
            bus.multiplicand = 32'd100;
            bus.multiplier   = 32'd100;
        end
        run_op(32'd2, 32'd2, 1'b1, 64'd4, "accept c18");
        bus.multiplicand = 32'h12345678;
        bus.multiplier   = 32'h9ABCDEF0;
        bus.is_signed    = 1'b1;
        bus.start        = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        clr_n = 1'b0;
        #1;
        chk("midrst product", {bus.product_hi, bus.product_lo}, 64'd0);
        chk("midrst ready", {63'd0, bus.ready}, 64'd1);
        chk("midrst busy", {63'd0, bus.busy}, 64'd0);
        chk("midrst done", {63'd0, bus.done}, 64'd0);
        @(posedge clk); #1;
        clr_n = 1'b1;
        run_op(32'd5, 32'd6, 1'b1, 64'd30, "after reset");
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
